// File: rtl/rf_dbg_port_pkg.sv
// rf_dbg_port_pkg
// Shared widths, FSM state encoding and a count-decoding helper for the
// register-file debug access engine (rf_dbg_port) and its bus interface.
package rf_dbg_port_pkg;

    localparam int RF_IDX_W   = 5;
    localparam int RF_DATA_W  = 32;
    localparam int DUMP_CNT_W = 6;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RADR  = 3'd1,
        ST_RDAT  = 3'd2,
        ST_SEND  = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    // A requested count of 0 means a full 32-register dump.
    function automatic logic [DUMP_CNT_W-1:0] dump_len(input logic [DUMP_CNT_W-1:0] cnt);
        return (cnt == '0) ? DUMP_CNT_W'(32) : cnt;
    endfunction

endpackage

// File: rtl/rf_dbg_port_if.sv
// rf_dbg_port_if
// Bundles every non-clock/reset signal of rf_dbg_port:
//   monitor side : dump_start/first/cnt, dump_done, dout/dout_idx/dout_valid/
//                  dout_ready, wr_req/wr_adr/wr_data, wr_ack
//   pipeline side: rf_sel, cpu_stall
//   reg-file side: rf_radr, rf_rdata, rf_wadr, rf_wdata, rf_wen
// Modports: slave = the debug engine, master = monitor + register file + pipeline.
interface rf_dbg_port_if;
    import rf_dbg_port_pkg::*;

    logic                  dump_start;
    logic [RF_IDX_W-1:0]   dump_first;
    logic [DUMP_CNT_W-1:0] dump_cnt;
    logic                  dump_done;
    logic [RF_DATA_W-1:0]  dout;
    logic [RF_IDX_W-1:0]   dout_idx;
    logic                  dout_valid;
    logic                  dout_ready;
    logic                  wr_req;
    logic [RF_IDX_W-1:0]   wr_adr;
    logic [RF_DATA_W-1:0]  wr_data;
    logic                  wr_ack;
    logic                  rf_sel;
    logic                  cpu_stall;
    logic [RF_IDX_W-1:0]   rf_radr;
    logic [RF_DATA_W-1:0]  rf_rdata;
    logic [RF_IDX_W-1:0]   rf_wadr;
    logic [RF_DATA_W-1:0]  rf_wdata;
    logic                  rf_wen;

    modport slave (
        input  dump_start, dump_first, dump_cnt, dout_ready,
        input  wr_req, wr_adr, wr_data, rf_rdata,
        output dump_done, dout, dout_idx, dout_valid, wr_ack,
        output rf_sel, cpu_stall, rf_radr, rf_wadr, rf_wdata, rf_wen
    );

    modport master (
        output dump_start, dump_first, dump_cnt, dout_ready,
        output wr_req, wr_adr, wr_data, rf_rdata,
        input  dump_done, dout, dout_idx, dout_valid, wr_ack,
        input  rf_sel, cpu_stall, rf_radr, rf_wadr, rf_wdata, rf_wen
    );

endinterface

// File: rtl/rf_dbg_port.sv
// rf_dbg_port
// Debug access engine for the 32x32 register file. Streams a contiguous,
// wrapping range of registers out over a valid/ready word port by sequencing
// the register file's registered-address read port, and (optionally) issues
// single debug writes. While busy it owns the RF ports and stalls the CPU.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - rf_dbg_port_if.slave (monitor, pipeline and register-file signals)
// Build option: define RF_DBG_WRITE_EN to include the debug write path
// (WRITE state, wr_ack, rf_wen/rf_wadr/rf_wdata). Without it those outputs
// are tied to 0 and wr_req/wr_adr/wr_data are ignored.
module rf_dbg_port
    import rf_dbg_port_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    rf_dbg_port_if.slave bus
);

    state_e                state_q,  state_d;
    logic [RF_IDX_W-1:0]   idx_q,    idx_d;
    logic [DUMP_CNT_W-1:0] remain_q, remain_d;
    logic [RF_DATA_W-1:0]  dout_q,   dout_d;
    logic [RF_IDX_W-1:0]   didx_q,   didx_d;
`ifdef RF_DBG_WRITE_EN
    logic [RF_IDX_W-1:0]   wadr_q,   wadr_d;
    logic [RF_DATA_W-1:0]  wdata_q,  wdata_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            remain_q <= '0;
            dout_q   <= '0;
            didx_q   <= '0;
`ifdef RF_DBG_WRITE_EN
            wadr_q   <= '0;
            wdata_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            remain_q <= remain_d;
            dout_q   <= dout_d;
            didx_q   <= didx_d;
`ifdef RF_DBG_WRITE_EN
            wadr_q   <= wadr_d;
            wdata_q  <= wdata_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        remain_d = remain_q;
        dout_d   = dout_q;
        didx_d   = didx_q;
`ifdef RF_DBG_WRITE_EN
        wadr_d   = wadr_q;
        wdata_d  = wdata_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                // A dump wins over a simultaneous write; that write is dropped.
                if (bus.dump_start) begin
                    idx_d    = bus.dump_first;
                    remain_d = dump_len(bus.dump_cnt);
                    state_d  = ST_RADR;
                end
`ifdef RF_DBG_WRITE_EN
                else if (bus.wr_req) begin
                    wadr_d  = bus.wr_adr;
                    wdata_d = bus.wr_data;
                    state_d = ST_WRITE;
                end
`endif
            end
            ST_RADR: state_d = ST_RDAT;
            ST_RDAT: begin
                // rf_rdata reflects the address presented during RADR.
                dout_d  = bus.rf_rdata;
                didx_d  = idx_q;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (bus.dout_ready) begin
                    idx_d    = idx_q + 1'b1;
                    remain_d = remain_q - 1'b1;
                    state_d  = (remain_q == DUMP_CNT_W'(1)) ? ST_DONE : ST_RADR;
                end
            end
            ST_DONE: state_d = ST_IDLE;
`ifdef RF_DBG_WRITE_EN
            ST_WRITE: state_d = ST_IDLE;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.rf_sel     = (state_q != ST_IDLE);
    assign bus.cpu_stall  = (state_q != ST_IDLE);
    assign bus.rf_radr    = (state_q == ST_RADR) ? idx_q : '0;
    assign bus.dout_valid = (state_q == ST_SEND);
    assign bus.dump_done  = (state_q == ST_DONE);
    assign bus.dout       = dout_q;
    assign bus.dout_idx   = didx_q;

`ifdef RF_DBG_WRITE_EN
    // x0 is hard-wired zero: acknowledge the write but never enable it.
    assign bus.wr_ack   = (state_q == ST_WRITE);
    assign bus.rf_wen   = (state_q == ST_WRITE) && (wadr_q != '0);
    assign bus.rf_wadr  = (state_q == ST_WRITE) ? wadr_q  : '0;
    assign bus.rf_wdata = (state_q == ST_WRITE) ? wdata_q : '0;
`else
    logic unused_wr;
    assign unused_wr    = ^{bus.wr_req, bus.wr_adr, bus.wr_data};
    assign bus.wr_ack   = 1'b0;
    assign bus.rf_wen   = 1'b0;
    assign bus.rf_wadr  = '0;
    assign bus.rf_wdata = '0;
`endif

endmodule

// File: tb/tb_rf_dbg_port.sv
// tb_rf_dbg_port
// Directed bench for rf_dbg_port with a registered-read register-file model.
module tb_rf_dbg_port;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    logic [31:0] mem [32];

    always #5 clk = ~clk;

    rf_dbg_port_if bus();

    rf_dbg_port dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Register file: registered read address, x[i] = 0x1000_0000 + i, x0 = 0.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++)
                mem[i] <= (i == 0) ? 32'h0 : 32'h1000_0000 + i;
        end else if (bus.rf_wen) begin
            mem[bus.rf_wadr] <= bus.rf_wdata;
        end
        bus.rf_rdata <= mem[bus.rf_radr];
    end

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] preload(input int i);
        return (i == 0) ? 32'h0 : 32'h1000_0000 + i;
    endfunction

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_dout"},   bus.dout,       32'h0);
        chk({tag, "_didx"},   bus.dout_idx,   32'h0);
        chk({tag, "_valid"},  bus.dout_valid, 32'h0);
        chk({tag, "_done"},   bus.dump_done,  32'h0);
        chk({tag, "_ack"},    bus.wr_ack,     32'h0);
        chk({tag, "_sel"},    bus.rf_sel,     32'h0);
        chk({tag, "_stall"},  bus.cpu_stall,  32'h0);
        chk({tag, "_radr"},   bus.rf_radr,    32'h0);
        chk({tag, "_wadr"},   bus.rf_wadr,    32'h0);
        chk({tag, "_wdata"},  bus.rf_wdata,   32'h0);
        chk({tag, "_wen"},    bus.rf_wen,     32'h0);
    endtask

    // Starts a dump with dout_ready held high and checks every word against
    // the supplied expectation table (indices wrap through the table).
    task automatic run_dump(input string tag, input logic [4:0] first,
                            input logic [5:0] cnt, input logic [31:0] exp_rf [32]);
        int   n;
        logic found;
        logic [4:0] ei;
        n = (cnt == 0) ? 32 : int'(cnt);
        bus.dump_first = first;
        bus.dump_cnt   = cnt;
        bus.dout_ready = 1'b1;
        bus.dump_start = 1'b1;
        tick();
        bus.dump_start = 1'b0;
        for (int w = 0; w < n; w++) begin
            found = 1'b0;
            for (int t = 0; t < 6 && !found; t++) begin
                if (bus.dout_valid) found = 1'b1;
                else tick();
            end
            if (!found) begin
                chk({tag, "_valid_timeout"}, 32'h0, 32'h1);
                return;
            end
            ei = first + 5'(w);
            chk({tag, "_idx"},  bus.dout_idx, 32'(ei));
            chk({tag, "_data"}, bus.dout,     exp_rf[ei]);
            tick();
        end
        chk({tag, "_done"},  bus.dump_done, 32'h1);
        tick();
        chk({tag, "_idle"},  bus.cpu_stall, 32'h0);
    endtask

    logic [31:0] exp_rf [32];
    logic        saw_ack;
    logic        saw_wen;
    logic        saw_done;

    initial begin
        for (int i = 0; i < 32; i++) exp_rf[i] = preload(i);
        rst            = 1'b1;
        bus.dump_start = 1'b0;
        bus.dump_first = '0;
        bus.dump_cnt   = '0;
        bus.dout_ready = 1'b0;
        bus.wr_req     = 1'b0;
        bus.wr_adr     = '0;
        bus.wr_data    = '0;
        tick();
        tick();
        check_idle_outputs("rst");
        rst = 1'b0;
        tick();

        // Cycle-exact 3-word dump from x5.
        bus.dump_first = 5'd5;
        bus.dump_cnt   = 6'd3;
        bus.dout_ready = 1'b1;
        bus.dump_start = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            tick();
            if (k == 1) bus.dump_start = 1'b0;
            chk("t5_valid", bus.dout_valid, 32'((k % 3 == 0) && (k <= 9)));
            chk("t5_done",  bus.dump_done,  32'(k == 10));
            chk("t5_stall", bus.cpu_stall,  32'(k <= 10));
            chk("t5_sel",   bus.rf_sel,     32'(k <= 10));
            case (k)
                1: chk("t5_radr", bus.rf_radr, 32'd5);
                3: begin chk("t5_idx0", bus.dout_idx, 32'd5); chk("t5_dat0", bus.dout, 32'h1000_0005); end
                6: begin chk("t5_idx1", bus.dout_idx, 32'd6); chk("t5_dat1", bus.dout, 32'h1000_0006); end
                9: begin chk("t5_idx2", bus.dout_idx, 32'd7); chk("t5_dat2", bus.dout, 32'h1000_0007); end
                default: ;
            endcase
        end

        // Wrap-around dump 30,31,0,1 with x0 reading zero.
        run_dump("wrap", 5'd30, 6'd4, exp_rf);

        // Full dump via count 0.
        run_dump("full", 5'd0, 6'd0, exp_rf);

        // Back-pressure: dout_ready low for 5 cycles in the first SEND.
        bus.dump_first = 5'd10;
        bus.dump_cnt   = 6'd2;
        bus.dout_ready = 1'b0;
        bus.dump_start = 1'b1;
        tick();
        bus.dump_start = 1'b0;
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", bus.dout_valid, 32'h1);
            chk("bp_idx",   bus.dout_idx,   32'd10);
            chk("bp_data",  bus.dout,       32'h1000_000A);
            chk("bp_stall", bus.cpu_stall,  32'h1);
            tick();
        end
        bus.dout_ready = 1'b1;
        tick();
        chk("bp_adv_valid", bus.dout_valid, 32'h0);
        tick();
        tick();
        chk("bp_idx2",  bus.dout_idx, 32'd11);
        chk("bp_data2", bus.dout,     32'h1000_000B);
        tick();
        chk("bp_done",  bus.dump_done, 32'h1);
        tick();

        // Debug write to x3, then to x0.
        bus.wr_req  = 1'b1;
        bus.wr_adr  = 5'd3;
        bus.wr_data = 32'hDEAD_BEEF;
        tick();
        bus.wr_req  = 1'b0;
`ifdef RF_DBG_WRITE_EN
        chk("wr_ack",   bus.wr_ack,    32'h1);
        chk("wr_wen",   bus.rf_wen,    32'h1);
        chk("wr_wadr",  bus.rf_wadr,   32'd3);
        chk("wr_wdata", bus.rf_wdata,  32'hDEAD_BEEF);
        chk("wr_stall", bus.cpu_stall, 32'h1);
        exp_rf[3] = 32'hDEAD_BEEF;
`else
        chk("wr_ack",   bus.wr_ack,    32'h0);
        chk("wr_wen",   bus.rf_wen,    32'h0);
        chk("wr_stall", bus.cpu_stall, 32'h0);
`endif
        tick();
        chk("wr_ack_end",  bus.wr_ack,    32'h0);
        chk("wr_idle",     bus.cpu_stall, 32'h0);
        run_dump("rdx3", 5'd3, 6'd1, exp_rf);

        bus.wr_req  = 1'b1;
        bus.wr_adr  = 5'd0;
        bus.wr_data = 32'h1234_5678;
        tick();
        bus.wr_req  = 1'b0;
`ifdef RF_DBG_WRITE_EN
        chk("wr0_ack", bus.wr_ack, 32'h1);
`else
        chk("wr0_ack", bus.wr_ack, 32'h0);
`endif
        chk("wr0_wen", bus.rf_wen, 32'h0);
        tick();
        run_dump("rdx0", 5'd0, 6'd1, exp_rf);

        // Simultaneous dump_start and wr_req: dump wins, write dropped.
        bus.wr_req     = 1'b1;
        bus.wr_adr     = 5'd3;
        bus.wr_data    = 32'h5555_AAAA;
        bus.dump_first = 5'd3;
        bus.dump_cnt   = 6'd1;
        bus.dout_ready = 1'b1;
        bus.dump_start = 1'b1;
        saw_ack = 1'b0;
        saw_wen = 1'b0;
        saw_done = 1'b0;
        tick();
        bus.dump_start = 1'b0;
        bus.wr_req     = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (bus.wr_ack) saw_ack = 1'b1;
            if (bus.rf_wen) saw_wen = 1'b1;
            if (bus.dout_valid) begin
                chk("col_data", bus.dout, exp_rf[3]);
            end
            if (bus.dump_done) saw_done = 1'b1;
            tick();
        end
        chk("col_no_ack", saw_ack,  32'h0);
        chk("col_no_wen", saw_wen,  32'h0);
        chk("col_done",   saw_done, 32'h1);

        // Reset two cycles into a dump aborts it.
        bus.dump_first = 5'd5;
        bus.dump_cnt   = 6'd3;
        bus.dump_start = 1'b1;
        tick();
        bus.dump_start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check_idle_outputs("abort");
        rst = 1'b0;
        saw_done = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (bus.dump_done || bus.dout_valid) saw_done = 1'b1;
            tick();
        end
        chk("abort_quiet", saw_done,      32'h0);
        chk("abort_stall", bus.cpu_stall, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rf_dbg_port.md
# rf_dbg_port

Debug access engine for the 32x32 integer register file. On request from the monitor, it sequences the register file's registered-address read port to stream a contiguous range of registers out over a valid/ready word interface. It also issues single debug writes through the register file's write port. It sits between the UART/debug monitor and the ID-stage register file. While it is busy it holds the CPU stalled and owns the read/write ports.

## Interface
Parameters:
- none; widths fixed at 5-bit register index, 32-bit data.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- dump_start  in  1  one-cycle request to start a dump; sampled only in IDLE
- dump_first  in  5  first register index
- dump_cnt  in  6  register count; 1..32, 0 is treated as 32
- dump_done  out  1  one-cycle pulse after the last word handshake
- dout  out  32  register value
- dout_idx  out  5  index of the register in dout
- dout_valid  out  1  dout/dout_idx valid
- dout_ready  in  1  consumer accepts the word when high with dout_valid
- wr_req  in  1  single debug write request (write feature only)
- wr_adr  in  5  debug write index
- wr_data  in  32  debug write data
- wr_ack  out  1  one-cycle pulse when the write has been issued
- rf_sel  out  1  high = this block owns the register-file ports; equals busy
- cpu_stall  out  1  stall request to the pipeline; equals rf_sel
- rf_radr  out  5  read address to the register file; captured by the register file on clk
- rf_rdata  in  32  register-file read data, valid the cycle after rf_radr is captured
- rf_wadr  out  5  register-file write address
- rf_wdata  out  32  register-file write data
- rf_wen  out  1  register-file write enable

## Operation
- States: IDLE, RADR, RDAT, SEND, WRITE, DONE.
- IDLE:
  - dump_start → latch idx=dump_first and remain=(dump_cnt==0 ? 32 : dump_cnt), then go to RADR.
  - Otherwise wr_req → latch wr_adr/wr_data, then go to WRITE.
  - dump_start has priority when both requests arrive in the same cycle; that wr_req is dropped and no wr_ack is given.
- RADR: rf_radr=idx; next state RDAT.
- RDAT: register dout=rf_rdata and dout_idx=idx; next state SEND.
- SEND:
  - dout_valid=1; dout and dout_idx are held stable until the handshake.
  - On dout_valid&&dout_ready: idx=idx+1 (5-bit wrap, 31→0) and remain=remain-1.
  - If remain was 1, go to DONE; otherwise go to RADR.
- DONE: dump_done=1 for one cycle; next state IDLE.
- WRITE:
  - rf_wen=1, rf_wadr and rf_wdata driven from the latched values, wr_ack=1 for one cycle; next state IDLE.
  - If the latched address is 0, rf_wen is forced to 0 so x0 stays zero; wr_ack still pulses.
- rf_sel and cpu_stall are high in every state except IDLE.
- rf_radr is 0 outside RADR; rf_wen is 0 outside WRITE.
- Requests arriving outside IDLE are ignored (no queuing).

## Timing
- Reset values: dout=0, dout_idx=0, dout_valid=0, dump_done=0, wr_ack=0, rf_sel=0, cpu_stall=0, rf_radr=0, rf_wadr=0, rf_wdata=0, rf_wen=0; state=IDLE.
- rst asserted mid-dump or mid-write aborts at the next edge:
  - no dump_done and no wr_ack are produced;
  - any in-flight word is discarded.
- Dump latency: the first dout_valid comes 3 cycles after dump_start is sampled (RADR, RDAT, then SEND).
- Per-word cost: 3 cycles with dout_ready held high.
- Dump total with dout_ready high: 3N+1 cycles from start to the dump_done pulse, then IDLE.
- Write latency: rf_wen and wr_ack come 1 cycle after wr_req is sampled; the block is back in IDLE the next cycle.

## Configuration
- RF_DBG_WRITE_EN defined: the write path, WRITE state and wr_ack are present.
- RF_DBG_WRITE_EN undefined:
  - wr_req, wr_adr and wr_data are ignored;
  - wr_ack, rf_wen, rf_wadr and rf_wdata are tied to 0;
  - the WRITE state is not built.

## Structure
- Shared package holds:
  - state encoding constants;
  - RF_IDX_W=5 and RF_DATA_W=32;
  - the dump count width of 6.
- Single module; no sub-module. The port-ownership mux lives in the ID stage and is driven by rf_sel.

## Test plan
- Register file preloaded with x[i]=0x1000_0000+i; dump_first=5, dump_cnt=3, ready=1 → words (5,0x10000005), (6,…06), (7,…07) at 3-cycle spacing; dump_done 10 cycles after start.
- dump_first=30, dump_cnt=4 → indices 30, 31, 0, 1; x0 reads 0.
- dump_cnt=0, dump_first=0 → 32 words with indices 0..31, then dump_done.
- dout_ready held low 5 cycles in the first SEND → dout and dout_idx stay stable and no index advance occurs; stall stays high throughout.
- wr_req with wr_adr=3, wr_data=0xDEADBEEF → rf_wen pulse with those values plus wr_ack; a following 1-word dump of x3 returns 0xDEADBEEF. wr_adr=0 → wr_ack with rf_wen=0.
- dump_start and wr_req in the same cycle → dump runs and no wr_ack. rst 2 cycles into a dump → all outputs return to reset values and no dump_done.
